// File: rtl/input_vc_buffer_pkg.sv
// Shared NoC types for the router input unit: flit format, port enum and VC state.
package params_noc;

  localparam int VC_NUM      = 4;
  localparam int BUF_DEPTH   = 4;
  localparam int VC_W        = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int COORD_W     = 4;
  localparam int PAYLOAD_W   = 8;
  localparam int in_Port_Cnt = 5;

  typedef enum logic [2:0] {
    LOCAL = 3'd0,
    NORTH = 3'd1,
    EAST  = 3'd2,
    SOUTH = 3'd3,
    WEST  = 3'd4
  } inout_Port;

  typedef enum logic [1:0] {
    HEAD      = 2'd0,
    BODY      = 2'd1,
    TAIL      = 2'd2,
    HEAD_TAIL = 2'd3
  } flit_type_e;

  typedef struct packed {
    flit_type_e           flit_type;
    logic [VC_W-1:0]      vc;
    logic [COORD_W-1:0]   dest_x;
    logic [COORD_W-1:0]   dest_y;
    logic [PAYLOAD_W-1:0] payload;
  } flit_t;

  typedef enum logic {
    VC_IDLE   = 1'b0,
    VC_ACTIVE = 1'b1
  } vc_state_e;

  function automatic logic is_head(input flit_type_e t);
    return (t == HEAD) || (t == HEAD_TAIL);
  endfunction

  function automatic logic is_tail(input flit_type_e t);
    return (t == TAIL) || (t == HEAD_TAIL);
  endfunction

endpackage

// File: rtl/input_vc_buffer_route_compute.sv
// XY dimension-order route computation: X is resolved before Y, equal coordinates go LOCAL.
module route_compute
  import params_noc::*;
#(
  parameter int x_Cur = 0,
  parameter int y_Cur = 0
) (
  input  logic [COORD_W-1:0] i_dest_x,
  input  logic [COORD_W-1:0] i_dest_y,
  output inout_Port          o_port
);

  always_comb begin
    o_port = LOCAL;
    if (int'(i_dest_x) > x_Cur)      o_port = EAST;
    else if (int'(i_dest_x) < x_Cur) o_port = WEST;
    else if (int'(i_dest_y) > y_Cur) o_port = NORTH;
    else if (int'(i_dest_y) < y_Cur) o_port = SOUTH;
  end

endmodule

// File: rtl/input_vc_buffer.sv
// Router input unit: per-VC flit FIFOs, head routing, switch requests, grant pop and credit return.
// Optional sticky protocol checker on error_o is built only with INPUT_VC_BUF_ERR_CHECK_EN.
module input_vc_buffer
  import params_noc::*;
#(
  parameter int vc_Num    = VC_NUM,
  parameter int buf_Depth = BUF_DEPTH,
  parameter int x_Cur     = 0,
  parameter int y_Cur     = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  flit_t             flit_i,
  input  logic              valid_i,
  output logic [vc_Num-1:0] credit_o,
  output logic [vc_Num-1:0] request_o,
  output inout_Port         out_port_o [vc_Num-1:0],
  input  logic [vc_Num-1:0] grant_i,
  output flit_t             flit_o,
  output logic              valid_o,
  output logic              error_o
);

  localparam int AW    = $clog2(buf_Depth);
  localparam int SEL_W = (vc_Num > 1) ? $clog2(vc_Num) : 1;

  flit_t       r_mem      [vc_Num-1:0][buf_Depth-1:0];
  logic [AW:0] r_wr_ptr   [vc_Num-1:0];
  logic [AW:0] r_rd_ptr   [vc_Num-1:0];
  vc_state_e   r_state    [vc_Num-1:0];
  vc_state_e   w_state_next [vc_Num-1:0];
  inout_Port   r_route    [vc_Num-1:0];
  inout_Port   w_route    [vc_Num-1:0];
  flit_t       w_head     [vc_Num-1:0];

  logic [vc_Num-1:0] w_empty;
  logic [vc_Num-1:0] w_full;
  logic [vc_Num-1:0] w_push;
  logic [vc_Num-1:0] w_wr_en;
  logic [vc_Num-1:0] w_pop;
  logic [vc_Num-1:0] w_grant_ok;
  logic [SEL_W-1:0]  w_sel;
  logic              w_any_pop;

  genvar gi;
  generate
    for (gi = 0; gi < vc_Num; gi++) begin : g_vc
      assign w_empty[gi] = (r_wr_ptr[gi] == r_rd_ptr[gi]);
      // Same slot index with differing wrap bits means the FIFO has lapped the reader.
      assign w_full[gi]  = (r_wr_ptr[gi][AW] != r_rd_ptr[gi][AW]) &&
                           (r_wr_ptr[gi][AW-1:0] == r_rd_ptr[gi][AW-1:0]);
      assign w_head[gi]  = r_mem[gi][r_rd_ptr[gi][AW-1:0]];
      assign w_push[gi]  = valid_i && (flit_i.vc == VC_W'(gi));
      assign w_wr_en[gi] = w_push[gi] && (!w_full[gi] || w_pop[gi]);
      assign request_o[gi] = (r_state[gi] == VC_ACTIVE) && !w_empty[gi];

      route_compute #(
        .x_Cur (x_Cur),
        .y_Cur (y_Cur)
      ) u_route (
        .i_dest_x (w_head[gi].dest_x),
        .i_dest_y (w_head[gi].dest_y),
        .o_port   (w_route[gi])
      );
    end
  endgenerate

  assign out_port_o = r_route;

  // Only the lowest-index VC among valid (requested and granted) bits is serviced.
  always_comb begin
    w_grant_ok = grant_i & request_o;
    w_pop      = '0;
    w_sel      = '0;
    w_any_pop  = 1'b0;
    for (int v = 0; v < vc_Num; v++) begin
      if (w_grant_ok[v] && !w_any_pop) begin
        w_pop[v]  = 1'b1;
        w_sel     = SEL_W'(v);
        w_any_pop = 1'b1;
      end
    end
  end

  always_comb begin
    for (int v = 0; v < vc_Num; v++) begin
      w_state_next[v] = r_state[v];
      case (r_state[v])
        VC_IDLE:   if (!w_empty[v] && is_head(w_head[v].flit_type)) w_state_next[v] = VC_ACTIVE;
        VC_ACTIVE: if (w_pop[v] && is_tail(w_head[v].flit_type))    w_state_next[v] = VC_IDLE;
        default:   w_state_next[v] = VC_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < vc_Num; v++) begin
        r_wr_ptr[v] <= '0;
        r_rd_ptr[v] <= '0;
        r_state[v]  <= VC_IDLE;
        r_route[v]  <= LOCAL;
      end
    end else begin
      for (int v = 0; v < vc_Num; v++) begin
        if (w_wr_en[v]) r_wr_ptr[v] <= r_wr_ptr[v] + (AW+1)'(1);
        if (w_pop[v])   r_rd_ptr[v] <= r_rd_ptr[v] + (AW+1)'(1);
        r_state[v] <= w_state_next[v];
        if (r_state[v] == VC_IDLE && w_state_next[v] == VC_ACTIVE) r_route[v] <= w_route[v];
      end
    end
  end

  // Storage is not reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    for (int v = 0; v < vc_Num; v++) begin
      if (w_wr_en[v]) r_mem[v][r_wr_ptr[v][AW-1:0]] <= flit_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flit_o   <= '0;
      valid_o  <= 1'b0;
      credit_o <= '0;
    end else begin
      valid_o  <= w_any_pop;
      credit_o <= w_pop;
      if (w_any_pop) flit_o <= w_head[w_sel];
    end
  end

`ifdef INPUT_VC_BUF_ERR_CHECK_EN
  logic [vc_Num-1:0] r_last_tail;
  logic              r_error;
  logic              w_err_set;

  always_comb begin
    w_err_set = 1'b0;
    for (int v = 0; v < vc_Num; v++) begin
      if (w_push[v] && !w_wr_en[v]) w_err_set = 1'b1;
      if (w_wr_en[v] && is_head(flit_i.flit_type) &&
          r_state[v] == VC_ACTIVE && !r_last_tail[v]) w_err_set = 1'b1;
      if (r_state[v] == VC_IDLE && !w_empty[v] && !is_head(w_head[v].flit_type)) w_err_set = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_tail <= '1;
      r_error     <= 1'b0;
    end else begin
      for (int v = 0; v < vc_Num; v++) begin
        if (w_wr_en[v]) r_last_tail[v] <= is_tail(flit_i.flit_type);
      end
      if (w_err_set) r_error <= 1'b1;
    end
  end

  assign error_o = r_error;
`else
  assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_input_vc_buffer.sv
// Self-checking bench for input_vc_buffer: queue-based reference model plus directed scenarios.
module tb_input_vc_buffer;
  import params_noc::*;

  localparam int NV = 4;
  localparam int DEPTH = 4;
`ifdef INPUT_VC_BUF_ERR_CHECK_EN
  localparam bit CHECKER_ON = 1'b1;
`else
  localparam bit CHECKER_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  flit_t         flit_i = '0;
  logic          valid_i = 1'b0;
  logic [NV-1:0] credit_o;
  logic [NV-1:0] request_o;
  inout_Port     out_port_o [NV-1:0];
  logic [NV-1:0] grant_i = '0;
  flit_t         flit_o;
  logic          valid_o;
  logic          error_o;

  int n_chk = 0;
  int n_err = 0;

  input_vc_buffer #(
    .vc_Num    (NV),
    .buf_Depth (DEPTH),
    .x_Cur     (1),
    .y_Cur     (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flit_i     (flit_i),
    .valid_i    (valid_i),
    .credit_o   (credit_o),
    .request_o  (request_o),
    .out_port_o (out_port_o),
    .grant_i    (grant_i),
    .flit_o     (flit_o),
    .valid_o    (valid_o),
    .error_o    (error_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic flit_t mk(input flit_type_e t, input int v, input int dx, input int dy, input int pl);
    flit_t f;
    f.flit_type = t;
    f.vc        = VC_W'(v);
    f.dest_x    = COORD_W'(dx);
    f.dest_y    = COORD_W'(dy);
    f.payload   = PAYLOAD_W'(pl);
    return f;
  endfunction

  // Router sits at (1,1): XY order, X first.
  function automatic inout_Port xy_route(input flit_t f);
    int dx, dy;
    dx = int'(f.dest_x);
    dy = int'(f.dest_y);
    if (dx > 1) return EAST;
    if (dx < 1) return WEST;
    if (dy > 1) return NORTH;
    if (dy < 1) return SOUTH;
    return LOCAL;
  endfunction

  function automatic bit head_kind(input flit_type_e t);
    return (t == HEAD) || (t == HEAD_TAIL);
  endfunction

  function automatic bit tail_kind(input flit_type_e t);
    return (t == TAIL) || (t == HEAD_TAIL);
  endfunction

  // ---------------- reference model ----------------
  flit_t     mq [NV][$];
  bit        m_routed [NV];
  inout_Port m_route [NV];
  bit        m_last_tail [NV];
  bit        m_err;
  bit        m_valid;
  flit_t     m_flit;
  logic [NV-1:0] m_credit;

  function automatic logic [NV-1:0] model_req();
    logic [NV-1:0] r;
    r = '0;
    for (int v = 0; v < NV; v++) r[v] = m_routed[v] && (mq[v].size() != 0);
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < NV; v++) begin
        mq[v].delete();
        m_routed[v]    = 1'b0;
        m_route[v]     = LOCAL;
        m_last_tail[v] = 1'b1;
      end
      m_err = 1'b0; m_valid = 1'b0; m_flit = '0; m_credit = '0;
    end else begin
      int sel;
      int wv;
      bit pre_routed [NV];
      logic [NV-1:0] req;
      req = model_req();
      sel = -1;
      for (int v = 0; v < NV; v++) begin
        pre_routed[v] = m_routed[v];
        if (sel < 0 && grant_i[v] && req[v]) sel = v;
      end
      for (int v = 0; v < NV; v++) begin
        if (!pre_routed[v] && mq[v].size() != 0) begin
          if (head_kind(mq[v][0].flit_type)) begin
            m_routed[v] = 1'b1;
            m_route[v]  = xy_route(mq[v][0]);
          end else if (CHECKER_ON) m_err = 1'b1;
        end
      end
      m_valid = 1'b0;
      m_credit = '0;
      if (sel >= 0) begin
        m_flit = mq[sel].pop_front();
        m_valid = 1'b1;
        m_credit[sel] = 1'b1;
        if (tail_kind(m_flit.flit_type)) m_routed[sel] = 1'b0;
      end
      if (valid_i) begin
        wv = int'(flit_i.vc);
        if (mq[wv].size() < DEPTH || sel == wv) begin
          if (CHECKER_ON && head_kind(flit_i.flit_type) && pre_routed[wv] && !m_last_tail[wv]) m_err = 1'b1;
          mq[wv].push_back(flit_i);
          m_last_tail[wv] = tail_kind(flit_i.flit_type);
        end else if (CHECKER_ON) m_err = 1'b1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      check("req", request_o, model_req());
      for (int v = 0; v < NV; v++) check($sformatf("port%0d", v), out_port_o[v], m_route[v]);
      check("valid", valid_o, m_valid);
      check("credit", credit_o, m_credit);
      if (m_valid) check("flit", flit_o, m_flit);
      check("error", error_o, m_err);
    end
  end

  // ---------------- pop bookkeeping for directed tests ----------------
  int cyc = 0;
  int pop_cnt = 0;
  int pop_first = 0;
  int pop_last = 0;
  int cred2 = 0;
  int last_pl = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst_n && valid_o) begin
      if (pop_cnt == 0) pop_first = cyc;
      pop_last = cyc;
      pop_cnt++;
      last_pl = int'(flit_o.payload);
    end
    if (rst_n && credit_o[2]) cred2++;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    valid_i = 1'b0;
    grant_i = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    #1;
  endtask

  task automatic put(input flit_t f);
    flit_i = f;
    valid_i = 1'b1;
  endtask

  flit_t f0;
  int rem [NV];

  initial begin
    // reset state
    do_reset();
    check("rst_req", request_o, 4'b0000);
    check("rst_valid", valid_o, 1'b0);
    check("rst_credit", credit_o, 4'b0000);
    check("rst_error", error_o, 1'b0);
    check("rst_flit", flit_o, 0);
    check("rst_port0", out_port_o[0], LOCAL);

    // single HEAD_TAIL on VC0 to (3,1)
    f0 = mk(HEAD_TAIL, 0, 3, 1, 8'hA5);
    put(f0);
    tick();
    valid_i = 1'b0;
    check("ht_req_idle", request_o, 4'b0000);
    tick();
    check("ht_req", request_o, 4'b0001);
    check("ht_port", out_port_o[0], EAST);
    grant_i = 4'b0001;
    tick();
    grant_i = '0;
    check("ht_valid", valid_o, 1'b1);
    check("ht_flit", flit_o, f0);
    check("ht_credit", credit_o, 4'b0001);
    check("ht_req_after", request_o, 4'b0000);
    tick();
    check("ht_valid_once", valid_o, 1'b0);
    $display("txn single_head_tail done");

    // wormhole 4-flit packet on VC2 to (1,0)
    do_reset();
    pop_cnt = 0; cred2 = 0;
    grant_i = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      put(mk(i == 0 ? HEAD : (i == 3 ? TAIL : BODY), 2, 1, 0, i));
      tick();
      if (i == 1) check("worm_port", out_port_o[2], SOUTH);
    end
    valid_i = 1'b0;
    repeat (6) tick();
    check("worm_pops", pop_cnt, 4);
    check("worm_consec", pop_last - pop_first, 3);
    check("worm_credits", cred2, 4);
    check("worm_last_pl", last_pl, 3);
    put(mk(HEAD_TAIL, 2, 1, 2, 9));
    tick();
    valid_i = 1'b0;
    tick();
    check("worm_reroute", out_port_o[2], NORTH);
    $display("txn wormhole done");

    // overflow on VC3
    do_reset();
    pop_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      put(mk(i == 0 ? HEAD : BODY, 3, 0, 1, i));
      tick();
    end
    valid_i = 1'b0;
    tick();
    check("ovf_port", out_port_o[3], WEST);
    check("ovf_error", error_o, CHECKER_ON);
    grant_i = 4'b1000;
    repeat (8) tick();
    grant_i = '0;
    check("ovf_pops", pop_cnt, 4);
    check("ovf_last_pl", last_pl, 3);
    $display("txn overflow done");

    // arbitration: lowest requesting+granted VC wins
    do_reset();
    put(mk(HEAD_TAIL, 1, 1, 1, 8'h11));
    tick();
    put(mk(HEAD_TAIL, 2, 1, 1, 8'h22));
    tick();
    valid_i = 1'b0;
    tick();
    check("arb_req", request_o, 4'b0110);
    check("arb_port1", out_port_o[1], LOCAL);
    grant_i = 4'b0110;
    tick();
    check("arb_credit", credit_o, 4'b0010);
    check("arb_pl", flit_o.payload, 8'h11);
    check("arb_req_left", request_o, 4'b0100);
    grant_i = 4'b1000;
    tick();
    check("arb_idle_valid", valid_o, 1'b0);
    check("arb_idle_credit", credit_o, 4'b0000);
    grant_i = 4'b0100;
    tick();
    grant_i = '0;
    check("arb_credit2", credit_o, 4'b0100);
    $display("txn arbitration done");

    // full VC0 with simultaneous push and pop
    do_reset();
    pop_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      put(mk(i == 0 ? HEAD : BODY, 0, 2, 2, i));
      tick();
    end
    valid_i = 1'b0;
    tick();
    put(mk(TAIL, 0, 2, 2, 4));
    grant_i = 4'b0001;
    tick();
    valid_i = 1'b0;
    check("full_credit", credit_o, 4'b0001);
    check("full_first_pl", flit_o.payload, 8'd0);
    repeat (6) tick();
    grant_i = '0;
    check("full_pops", pop_cnt, 5);
    check("full_last_pl", last_pl, 4);
    check("full_error", error_o, 1'b0);
    check("full_req", request_o, 4'b0000);
    $display("txn full_push_pop done");

    // reset mid-traffic with VC1 holding 2 flits
    do_reset();
    for (int i = 0; i < 3; i++) begin
      put(mk(i == 0 ? HEAD : BODY, 1, 0, 0, i));
      tick();
    end
    valid_i = 1'b0;
    grant_i = 4'b0010;
    tick();
    grant_i = '0;
    check("mid_pre_valid", valid_o, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_req", request_o, 4'b0000);
    check("mid_valid", valid_o, 1'b0);
    check("mid_credit", credit_o, 4'b0000);
    check("mid_port1", out_port_o[1], LOCAL);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    #1;
    pop_cnt = 0;
    grant_i = 4'b1111;
    repeat (3) tick();
    grant_i = '0;
    check("mid_empty_req", request_o, 4'b0000);
    check("mid_empty_pops", pop_cnt, 0);
    $display("txn reset_mid_traffic done");

    // randomized traffic against the model
    do_reset();
    for (int v = 0; v < NV; v++) rem[v] = 0;
    for (int c = 0; c < 3000; c++) begin
      int v;
      int len;
      flit_type_e t;
      valid_i = 1'b0;
      if ($urandom_range(0, 99) < 60) begin
        v = $urandom_range(0, NV-1);
        if (rem[v] == 0) begin
          len = $urandom_range(1, 4);
          t = (len == 1) ? HEAD_TAIL : HEAD;
          rem[v] = len - 1;
        end else begin
          rem[v]--;
          t = (rem[v] == 0) ? TAIL : BODY;
        end
        put(mk(t, v, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 255)));
      end
      grant_i = ($urandom_range(0, 99) < 70) ? NV'($urandom_range(0, 15)) : '0;
      tick();
    end
    valid_i = 1'b0;
    grant_i = '0;
    tick();
    $display("txn random_traffic done");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
